// File: rtl/sender_arbiter_pkg.sv
// Shared constants for the bundled-data channel: default bus width, counter
// width and the 2-bit state encoding used by the sender.
package sender_arbiter_pkg;

    localparam int unsigned DATA_MSB_DEF = 7;
    localparam int unsigned CNT_W        = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_REQ_HI = 2'd2;
    localparam logic [1:0] ST_REQ_LO = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        LOAD   = ST_LOAD,
        REQ_HI = ST_REQ_HI,
        REQ_LO = ST_REQ_LO
    } state_t;

endpackage

// File: rtl/sender_arbiter_dffs.sv
// Single D flop with asynchronous active-high reset to zero.
module sender_arbiter_dffs (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/sender_arbiter_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the local clock.
module sender_arbiter_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    sender_arbiter_dffs u_ack_m (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (meta)
    );

    sender_arbiter_dffs u_ack_s (
        .clk   (clk),
        .reset (reset),
        .d     (meta),
        .q     (q)
    );

endmodule

// File: rtl/sender_arbiter.sv
// Transmit side of the 4-phase bundled-data channel: round-robin arbitration
// among NSRC sources and full req/ack sequencing of each transfer.
module sender_arbiter
    import sender_arbiter_pkg::*;
#(
    parameter int unsigned DATA_MSB = DATA_MSB_DEF,
    parameter int unsigned NSRC     = 4
) (
    input  logic                         clk_tx,
    input  logic                         reset,
    input  logic [NSRC-1:0]              src_valid,
    input  logic [NSRC*(DATA_MSB+1)-1:0] src_data,
    output logic [NSRC-1:0]              src_done,
    output logic                         req,
    output logic [DATA_MSB:0]            data,
    input  logic                         ack,
    output logic                         busy,
    output logic [CNT_W-1:0]             xfer_cnt
);

    localparam int unsigned DW = DATA_MSB + 1;
    localparam int unsigned SW = $clog2(NSRC);

    state_t            state;
    state_t            state_nxt;
    logic              ack_s;
    logic [1:0]        fill;
    logic [SW-1:0]     ptr;
    logic [SW-1:0]     ptr_nxt;
    logic [SW-1:0]     gid;
    logic [SW-1:0]     gid_nxt;
    logic [SW-1:0]     win;
    logic              found;
    int unsigned       idx;
    logic              req_nxt;
    logic [DW-1:0]     data_nxt;
    logic [NSRC-1:0]   done_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DW-1:0]     words [NSRC];

    sender_arbiter_sync2 u_ack_sync (
        .clk   (clk_tx),
        .reset (reset),
        .d     (ack),
        .q     (ack_s)
    );

    for (genvar g = 0; g < NSRC; g++) begin : g_word
        assign words[g] = src_data[g*DW +: DW];
    end

    // Priority encoder rotated so that the search starts at ptr.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            if (!found && src_valid[SW'(idx)]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt = state;
        req_nxt   = req;
        data_nxt  = data;
        gid_nxt   = gid;
        ptr_nxt   = ptr;
        done_nxt  = '0;
        cnt_nxt   = xfer_cnt;
        case (state)
            IDLE: begin
                // fill[1] keeps the guard honest until ack_s reflects the real ack after reset.
                if (found && !ack_s && fill[1]) begin
                    data_nxt  = words[win];
                    gid_nxt   = win;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                req_nxt   = 1'b1;
                state_nxt = REQ_HI;
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_nxt       = 1'b0;
                    done_nxt[gid] = 1'b1;
                    cnt_nxt       = xfer_cnt + CNT_W'(1);
                    state_nxt     = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    ptr_nxt   = (gid == SW'(NSRC - 1)) ? '0 : gid + SW'(1);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_tx or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            req      <= 1'b0;
            data     <= '0;
            src_done <= '0;
            xfer_cnt <= '0;
            ptr      <= '0;
            gid      <= '0;
            fill     <= '0;
        end else begin
            state    <= state_nxt;
            req      <= req_nxt;
            data     <= data_nxt;
            src_done <= done_nxt;
            xfer_cnt <= cnt_nxt;
            ptr      <= ptr_nxt;
            gid      <= gid_nxt;
            fill     <= {fill[0], 1'b1};
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sender_arbiter.sv
// Directed bench for sender_arbiter with a simple 4-phase receiver model.
module tb_sender_arbiter;

    localparam int unsigned NSRC = 4;
    localparam int unsigned DW   = 8;

    logic              clk_tx = 1'b0;
    logic              reset;
    logic [NSRC-1:0]   src_valid;
    logic [NSRC*DW-1:0] src_data;
    logic [NSRC-1:0]   src_done;
    logic              req;
    logic [DW-1:0]     data;
    logic              ack;
    logic              busy;
    logic [15:0]       xfer_cnt;

    int   tests;
    int   fails;

    logic rx_auto;
    logic ack_force;
    int   rx_lat;
    int   rx_fall_extra;
    int   rx_cnt;

    sender_arbiter #(.DATA_MSB(7), .NSRC(4)) dut (
        .clk_tx    (clk_tx),
        .reset     (reset),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_done  (src_done),
        .req       (req),
        .data      (data),
        .ack       (ack),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk_tx = ~clk_tx;

    // Receiver: ack follows req after rx_lat cycles (plus rx_fall_extra on the fall), or is forced.
    initial begin
        ack    = 1'b0;
        rx_cnt = 0;
        forever begin
            @(negedge clk_tx);
            if (!rx_auto) begin
                ack    = ack_force;
                rx_cnt = 0;
            end else if (req != ack) begin
                rx_cnt++;
                if (rx_cnt >= (req ? rx_lat : rx_lat + rx_fall_extra)) begin
                    ack    = req;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk_tx);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        rx_auto   = 1'b0;
        ack_force = 1'b0;
        src_valid = 4'b1111;
        src_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        reset     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick;
            tests++;
            if (req !== 1'b0 || data !== 8'h00 || busy !== 1'b0 || xfer_cnt !== 16'h0000 || src_done !== 4'b0000) begin
                fails++;
                $display("FAIL reset_c%0d: req=%b data=%h busy=%b cnt=%h done=%b, required all zero",
                         c, req, data, busy, xfer_cnt, src_done);
            end
        end
        src_valid = '0;
        reset     = 1'b0;
        tick;
        rx_auto = 1'b1;
    endtask

    task automatic test_single;
        int         ack_seen;
        int         done_seen;
        int         pulses;
        logic       prev_req;
        logic [7:0] prev_data;
        logic       got_rise;
        rx_lat        = 3;
        rx_fall_extra = 0;
        src_data[16 +: 8] = 8'hA5;
        src_valid = 4'b0100;
        prev_req  = 1'b0;
        prev_data = 8'h00;
        pulses    = 0;
        ack_seen  = -1;
        done_seen = -1;
        got_rise  = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick;
            if (req && !prev_req) begin
                got_rise = 1'b1;
                tests++;
                if (prev_data !== 8'hA5 || data !== 8'hA5 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL single_setup: data before req=%h at req=%h busy=%b, required A5 A5 1",
                             prev_data, data, busy);
                end
            end
            if (ack && ack_seen < 0) ack_seen = c;
            if (src_done !== 4'b0000) begin
                pulses++;
                if (done_seen < 0) done_seen = c;
                tests++;
                if (src_done !== 4'b0100) begin
                    fails++;
                    $display("FAIL single_done: src_done=%b, required 0100", src_done);
                end
                src_valid = '0;
            end
            prev_req  = req;
            prev_data = data;
            if (done_seen >= 0 && !busy) break;
        end
        tests++;
        if (!got_rise || pulses != 1) begin
            fails++;
            $display("FAIL single_pulses: req_rise=%b done_pulses=%0d, required 1 1", got_rise, pulses);
        end
        tests++;
        if (ack_seen < 0 || done_seen != ack_seen + 2) begin
            fails++;
            $display("FAIL single_sync_latency: done at cycle %0d, ack at %0d, required ack+2", done_seen, ack_seen);
        end
        tests++;
        if (xfer_cnt !== 16'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_cnt: xfer_cnt=%0d busy=%b, required 1 0", xfer_cnt, busy);
        end
    endtask

    task automatic test_fairness;
        logic [7:0] exp_data [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        logic [3:0] exp_done;
        logic [3:0] pend;
        logic       prev_req;
        int         grants;
        int         dones;
        do_reset;
        src_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        src_valid = 4'b1111;
        pend      = '0;
        prev_req  = 1'b0;
        grants    = 0;
        dones     = 0;
        for (int c = 0; c < 300; c++) begin
            tick;
            if (pend != 4'b0000) begin
                src_valid = src_valid | pend;
                pend      = '0;
            end
            if (req && !prev_req) begin
                if (grants < 5) begin
                    tests++;
                    if (data !== exp_data[grants]) begin
                        fails++;
                        $display("FAIL fair_data_%0d: data=%h, required %h", grants, data, exp_data[grants]);
                    end
                end
                grants++;
            end
            if (src_done !== 4'b0000) begin
                exp_done = 4'b0001 << (dones % 4);
                tests++;
                if (src_done !== exp_done) begin
                    fails++;
                    $display("FAIL fair_done_%0d: src_done=%b, required %b", dones, src_done, exp_done);
                end
                dones++;
                if (dones >= 5) begin
                    src_valid = '0;
                end else begin
                    src_valid = src_valid & ~src_done;
                    pend      = src_done;
                end
            end
            prev_req = req;
            if (dones >= 5 && !busy) break;
        end
        tests++;
        if (grants != 5 || dones != 5 || xfer_cnt !== 16'd5) begin
            fails++;
            $display("FAIL fair_end: grants=%0d dones=%0d xfer_cnt=%0d, required 5 5 5", grants, dones, xfer_cnt);
        end
    endtask

    task automatic test_rtz_guard;
        int   phase;
        int   fell_c;
        int   rise_c;
        logic prev_req;
        rx_lat        = 3;
        rx_fall_extra = 10;
        src_data[8 +: 8]  = 8'h5C;
        src_data[24 +: 8] = 8'h3E;
        src_valid = 4'b0010;
        phase     = 0;
        fell_c    = -1;
        rise_c    = -1;
        prev_req  = req;
        for (int c = 0; c < 200; c++) begin
            tick;
            case (phase)
                0: begin
                    if (src_done !== 4'b0000) begin
                        tests++;
                        if (src_done !== 4'b0010) begin
                            fails++;
                            $display("FAIL rtz_first_done: src_done=%b, required 0010", src_done);
                        end
                        src_valid = 4'b1000;
                        phase     = 1;
                    end
                end
                1: begin
                    if (req && !prev_req) begin
                        rise_c = c;
                        phase  = 2;
                        tests++;
                        if (data !== 8'h3E) begin
                            fails++;
                            $display("FAIL rtz_data: data=%h, required 3E", data);
                        end
                        tests++;
                        if (fell_c < 0 || rise_c != fell_c + 4) begin
                            fails++;
                            $display("FAIL rtz_latency: req rose at cycle %0d, ack fell at %0d, required fall+4",
                                     rise_c, fell_c);
                        end
                    end else if (ack) begin
                        tests++;
                        if (req !== 1'b0) begin
                            fails++;
                            $display("FAIL rtz_hold: req=%b while ack high, required 0", req);
                        end
                    end else if (fell_c < 0) begin
                        fell_c = c;
                    end
                end
                2: begin
                    if (src_done !== 4'b0000) begin
                        tests++;
                        if (src_done !== 4'b1000) begin
                            fails++;
                            $display("FAIL rtz_second_done: src_done=%b, required 1000", src_done);
                        end
                        src_valid = '0;
                        phase     = 3;
                    end
                end
                default: ;
            endcase
            prev_req = req;
            if (phase == 3 && !busy) break;
        end
        tests++;
        if (phase != 3 || xfer_cnt !== 16'd7) begin
            fails++;
            $display("FAIL rtz_end: phase=%0d xfer_cnt=%0d, required 3 7", phase, xfer_cnt);
        end
        rx_fall_extra = 0;
    endtask

    task automatic test_reset_mid;
        logic got_req;
        logic rose;
        logic done;
        rx_lat   = 3;
        rx_auto  = 1'b1;
        src_data[0 +: 8] = 8'h77;
        src_valid = 4'b0001;
        got_req   = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick;
            if (req) begin
                got_req = 1'b1;
                break;
            end
        end
        tests++;
        if (!got_req) begin
            fails++;
            $display("FAIL mid_no_req: req=%b, required 1 within 50 cycles", req);
        end
        rx_auto   = 1'b0;
        ack_force = 1'b1;
        @(negedge clk_tx);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if (req !== 1'b0 || src_done !== 4'b0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_async: req=%b done=%b busy=%b, required 0 0000 0", req, src_done, busy);
        end
        tick;
        tick;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            tests++;
            if (req !== 1'b0 || busy !== 1'b0 || src_done !== 4'b0000) begin
                fails++;
                $display("FAIL mid_guard_c%0d: req=%b busy=%b done=%b with ack high, required 0 0 0000",
                         c, req, busy, src_done);
            end
        end
        ack_force = 1'b0;
        rose = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick;
            if (req && !rose) begin
                rose = 1'b1;
                tests++;
                if (data !== 8'h77) begin
                    fails++;
                    $display("FAIL mid_data: data=%h, required 77", data);
                end
                rx_auto = 1'b1;
            end
            if (src_done !== 4'b0000) begin
                done = 1'b1;
                tests++;
                if (src_done !== 4'b0001 || xfer_cnt !== 16'd1) begin
                    fails++;
                    $display("FAIL mid_done: src_done=%b xfer_cnt=%0d, required 0001 1", src_done, xfer_cnt);
                end
                src_valid = '0;
            end
            if (done && !busy) break;
        end
        tests++;
        if (!rose || !done) begin
            fails++;
            $display("FAIL mid_served: req_rose=%b done=%b, required 1 1", rose, done);
        end
    endtask

    task automatic test_counter_wrap;
        logic [15:0] exp_cnt [3] = '{16'hFFFF, 16'h0000, 16'h0001};
        int dones;
        force dut.xfer_cnt = 16'hFFFE;
        tick;
        tick;
        release dut.xfer_cnt;
        tick;
        tests++;
        if (xfer_cnt !== 16'hFFFE) begin
            fails++;
            $display("FAIL wrap_preload: xfer_cnt=%h, required FFFE", xfer_cnt);
        end
        rx_lat = 1;
        src_data[16 +: 8] = 8'h42;
        src_valid = 4'b0100;
        dones     = 0;
        for (int c = 0; c < 200; c++) begin
            tick;
            if (src_done !== 4'b0000 && dones < 3) begin
                tests++;
                if (xfer_cnt !== exp_cnt[dones] || src_done !== 4'b0100) begin
                    fails++;
                    $display("FAIL wrap_%0d: xfer_cnt=%h src_done=%b, required %h 0100",
                             dones, xfer_cnt, src_done, exp_cnt[dones]);
                end
                dones++;
                if (dones == 3) src_valid = '0;
            end
            if (dones == 3 && !busy) break;
        end
        tests++;
        if (dones != 3) begin
            fails++;
            $display("FAIL wrap_count: transfers=%0d, required 3", dones);
        end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        reset         = 1'b1;
        src_valid     = '0;
        src_data      = '0;
        rx_auto       = 1'b0;
        ack_force     = 1'b0;
        rx_lat        = 3;
        rx_fall_extra = 0;
        test_reset;
        test_single;
        test_fairness;
        test_rtz_guard;
        test_reset_mid;
        test_counter_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
